// File: rtl/io_bank_ccff_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bank_ccff_cfg
//  Description : IO bank tile with NUM_IO bidirectional pads behind a shadowed
//                serial configuration chain. Bits shift in on ccff_head and
//                only reach the pads on a validated commit. ccff_tail
//                daisy-chains the shift register to the next tile.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_bank_ccff_cfg #(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_shift_en,
  input  logic              ccff_head,
  input  logic              ccff_commit,
  output logic              ccff_tail,
  output logic              cfg_ready,
  output logic              cfg_done,
  output logic              cfg_err,
  inout  wire  [NUM_IO-1:0] gfpga_pad_iopad_pad,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad
);

  localparam int FRAME_LEN = NUM_IO * CFG_BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  // Load state is a pure function of the bit counter, so it is decoded rather
  // than stored; this keeps state and count from ever disagreeing.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  state_e                 state;
  logic [FRAME_LEN-1:0]   sr_q, sr_d;
  logic [FRAME_LEN-1:0]   active_q, active_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tail_q, tail_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   w_accept;
  logic [FRAME_LEN:0]     w_sr_ext;

  assign w_sr_ext = {sr_q, ccff_head};

  // Decode the load state from the bit counter.
  always_comb begin
    state = ST_LOADING;
    if (cnt_q == '0) begin
      state = ST_EMPTY;
    end else if (cnt_q == C_CNT_FULL) begin
      state = ST_FULL;
    end
  end

  // Next-state logic for the shift chain, counter, shadow copy and pulses.
  always_comb begin
    sr_d     = sr_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    tail_d   = sr_q[FRAME_LEN-1];
    // A commit only lands on a complete frame with no shift in flight.
    w_accept = ccff_commit && !ccff_shift_en && (state == ST_FULL);
    done_d   = w_accept;
    err_d    = ccff_commit && !w_accept;

    if (ccff_shift_en) begin
      sr_d = w_sr_ext[FRAME_LEN-1:0];
      // Counter saturates; extra bits keep flowing out to the next tile.
      if (cnt_q != C_CNT_FULL) begin
        cnt_d = cnt_q + C_CNT_ONE;
      end
    end

    // The shift register is deliberately left intact after a commit.
    if (w_accept) begin
      active_d = sr_q;
      cnt_d    = '0;
    end
  end

  // Configuration-domain registers with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_q     <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      tail_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      tail_q   <= tail_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail = tail_q;
  assign cfg_ready = (cnt_q == C_CNT_FULL);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  // Pads are driven only from the committed copy, so shifting never glitches
  // them. The inverted read-back also applies while driving, for loopback.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_pad
      assign gfpga_pad_iopad_pad[gi] = active_q[gi*CFG_BITS] ? io_outpad[gi] : 1'bz;
      assign io_inpad[gi] = gfpga_pad_iopad_pad[gi] ^ active_q[gi*CFG_BITS+1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_io_bank_ccff_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_bank_ccff_cfg
//  Description : Self-checking bench for io_bank_ccff_cfg; directed scenarios
//                followed by random shift/commit/reset traffic compared against
//                a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_bank_ccff_cfg;

  localparam int NUM_IO    = 4;
  localparam int CFG_BITS  = 2;
  localparam int FRAME_LEN = NUM_IO * CFG_BITS;

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b1;
  logic              ccff_shift_en = 1'b0;
  logic              ccff_head = 1'b0;
  logic              ccff_commit = 1'b0;
  logic              ccff_tail, cfg_ready, cfg_done, cfg_err;
  wire  [NUM_IO-1:0] pad;
  logic [NUM_IO-1:0] io_outpad = '0;
  logic [NUM_IO-1:0] io_inpad;
  logic [NUM_IO-1:0] ext_en = '0;
  logic [NUM_IO-1:0] ext_val = '0;

  always #5 prog_clk = ~prog_clk;

  // External pad drivers stand in for the board.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_IO; gi++) begin : g_ext
      assign pad[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
    end
  endgenerate

  io_bank_ccff_cfg #(.NUM_IO(NUM_IO), .CFG_BITS(CFG_BITS)) u_dut (
    .prog_clk            (prog_clk),
    .pReset              (pReset),
    .ccff_shift_en       (ccff_shift_en),
    .ccff_head           (ccff_head),
    .ccff_commit         (ccff_commit),
    .ccff_tail           (ccff_tail),
    .cfg_ready           (cfg_ready),
    .cfg_done            (cfg_done),
    .cfg_err             (cfg_err),
    .gfpga_pad_iopad_pad (pad),
    .io_outpad           (io_outpad),
    .io_inpad            (io_inpad)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: history of every bit shifted since reset, the number of
  // bits in the current frame, and the committed configuration.
  bit shq[$];
  int m_cnt = 0;
  bit m_act[FRAME_LEN];
  bit m_tail, m_done, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit k of the chain holds the bit shifted k shifts ago (0 if none yet).
  function automatic bit sr_bit(input int k);
    if (shq.size() > k) return shq[shq.size() - 1 - k];
    return 1'b0;
  endfunction

  task automatic cyc(input bit rs, input bit sh, input bit hd, input bit cm);
    bit acc;
    pReset        = rs;
    ccff_shift_en = sh;
    ccff_head     = hd;
    ccff_commit   = cm;
    @(posedge prog_clk);
    if (rs) begin
      shq.delete();
      m_cnt  = 0;
      m_tail = 0;
      m_done = 0;
      m_err  = 0;
      for (int k = 0; k < FRAME_LEN; k++) m_act[k] = 0;
    end else begin
      m_tail = sr_bit(FRAME_LEN - 1);
      acc    = cm && !sh && (m_cnt == FRAME_LEN);
      m_done = acc;
      m_err  = cm && !acc;
      if (acc) begin
        for (int k = 0; k < FRAME_LEN; k++) m_act[k] = sr_bit(k);
        m_cnt = 0;
      end
      if (sh) begin
        shq.push_back(hd);
        if (shq.size() > FRAME_LEN + 1) void'(shq.pop_front());
        if (m_cnt < FRAME_LEN) m_cnt++;
      end
    end
    #1;
    chk("ccff_tail", ccff_tail, m_tail);
    chk("cfg_ready", cfg_ready, m_cnt == FRAME_LEN);
    chk("cfg_done", cfg_done, m_done);
    chk("cfg_err", cfg_err, m_err);
  endtask

  // Drive random fabric data, drive undriven pads externally, check both paths.
  task automatic pads(input string tag);
    bit en, inv;
    io_outpad = NUM_IO'($urandom);
    ext_val   = NUM_IO'($urandom);
    for (int i = 0; i < NUM_IO; i++) ext_en[i] = !m_act[i*CFG_BITS];
    #1;
    for (int i = 0; i < NUM_IO; i++) begin
      en  = m_act[i*CFG_BITS];
      inv = m_act[i*CFG_BITS+1];
      if (en) begin
        chk($sformatf("%s_pad%0d", tag, i), pad[i], io_outpad[i]);
        chk($sformatf("%s_in%0d", tag, i), io_inpad[i], io_outpad[i] ^ inv);
      end else begin
        chk($sformatf("%s_hiz_in%0d", tag, i), io_inpad[i], ext_val[i] ^ inv);
      end
    end
  endtask

  task automatic shift_frame(input logic [FRAME_LEN-1:0] fr);
    for (int k = FRAME_LEN - 1; k >= 0; k--) cyc(0, 1, fr[k], 0);
  endtask

  initial begin
    logic [FRAME_LEN-1:0] fr;

    // Reset for two cycles, then an early commit must be rejected.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    pads("rst");
    cyc(0, 0, 0, 1);
    pads("rst_commit");

    // Enable pad0 only, no inversion.
    fr = 8'b00_00_00_01;
    shift_frame(fr);
    cyc(0, 0, 0, 1);
    pads("en0");

    // Partial frame commit is rejected, completed frame accepted.
    for (int k = 0; k < 5; k++) cyc(0, 1, 1'($urandom), 0);
    cyc(0, 0, 0, 1);
    pads("partial");
    for (int k = 0; k < 3; k++) cyc(0, 1, 1'($urandom), 0);
    cyc(0, 0, 0, 1);
    pads("complete");

    // pad0 inverted and undriven; external 1 reads back as 0.
    fr = 8'b00_00_00_10;
    shift_frame(fr);
    cyc(0, 0, 0, 1);
    pads("inv0");
    ext_en[0]  = 1'b1;
    ext_val[0] = 1'b1;
    #1;
    chk("inv0_ext1", io_inpad[0], 1'b0);

    // Over-length shift streams through the tail; commit during shift fails.
    for (int k = 0; k < 12; k++) cyc(0, 1, 1'($urandom), 0);
    cyc(0, 1, 1'($urandom), 1);
    cyc(0, 0, 0, 1);
    pads("overlen");

    // Reset partway through a new frame drops everything.
    for (int k = 0; k < 4; k++) cyc(0, 1, 1'($urandom), 0);
    cyc(1, 0, 0, 0);
    pads("midrst");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 65),
          1'($urandom), ($urandom_range(0, 99) < 20));
      if ((n % 4) == 0) pads("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
